// File: rtl/exe_muldiv.sv
//=============================================================================
// Module      : exe_muldiv
// Description : RISC-V M-extension multiply/divide unit. Restoring radix-2
//               divider and shift-add multiplier share one datapath.
//               Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module exe_muldiv #(
   parameter int DATA_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [2:0]             funct3_i,
   input  logic [DATA_WIDTH-1:0]  op1_i,
   input  logic [DATA_WIDTH-1:0]  op2_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   flush_i,
   output logic                   busy_o,
   output logic                   reg_we_o,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic [DATA_WIDTH-1:0]  reg_wdata_o
);

   localparam int                 c_cnt_w    = $clog2(DATA_WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);
   localparam logic [1:0]         c_idle     = 2'd0;
   localparam logic [1:0]         c_calc     = 2'd1;
   localparam logic [1:0]         c_done     = 2'd2;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [DATA_WIDTH-1:0]  r_hi;
   logic [DATA_WIDTH-1:0]  r_lo;
   logic [DATA_WIDTH-1:0]  r_b;
   logic                   r_neg;
   logic [2:0]             r_funct;
   logic [RADDR_WIDTH-1:0] r_waddr;

   logic                    w_accept, w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2;
   logic                    w_res_neg, w_div_zero, w_div_ovf, w_skip;
   logic [DATA_WIDTH-1:0]   w_mag1, w_mag2;
   logic [DATA_WIDTH-1:0]   w_init_hi, w_init_lo, w_init_b;
   logic                    w_init_neg;
   logic [DATA_WIDTH:0]     w_sum, w_shift, w_diff;
   logic [DATA_WIDTH-1:0]   w_step_hi, w_step_lo;
   logic [2*DATA_WIDTH-1:0] w_prod;
   logic [DATA_WIDTH-1:0]   w_quo, w_rem, w_result;

   // Operand decode: signedness per op, magnitudes and result sign
   assign w_accept   = start_i & ~flush_i;
   assign w_is_div   = funct3_i[2];
   assign w_sgn1     = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                       (funct3_i == 3'd4) || (funct3_i == 3'd6);
   assign w_sgn2     = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
   assign w_neg1     = w_sgn1 & op1_i[DATA_WIDTH-1];
   assign w_neg2     = w_sgn2 & op2_i[DATA_WIDTH-1];
   assign w_mag1     = w_neg1 ? -op1_i : op1_i;
   assign w_mag2     = w_neg2 ? -op2_i : op2_i;
   assign w_res_neg  = (funct3_i == 3'd6) ? w_neg1 : (w_neg1 ^ w_neg2);
   assign w_div_zero = (op2_i == '0);
   assign w_div_ovf  = w_is_div & w_sgn2 & (op2_i == '1) &
                       (op1_i == {1'b1, {(DATA_WIDTH-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
   logic [2*DATA_WIDTH-1:0] w_fast_a, w_fast_b, w_fast_prod;
   assign w_fast_a    = {{DATA_WIDTH{w_neg1}}, op1_i};
   assign w_fast_b    = {{DATA_WIDTH{w_neg2}}, op2_i};
   assign w_fast_prod = w_fast_a * w_fast_b;
   assign w_skip      = ~w_is_div | w_div_zero | w_div_ovf;
`else
   assign w_skip      = w_is_div & (w_div_zero | w_div_ovf);
`endif

   // Initial datapath load; special division cases preload the final answer
   always_comb begin
      w_init_hi  = '0;
      w_init_lo  = w_mag1;
      w_init_b   = w_mag2;
      w_init_neg = w_res_neg;
      if (w_is_div) begin
         if (w_div_zero) begin
            w_init_hi  = op1_i;
            w_init_lo  = '1;
            w_init_neg = 1'b0;
         end else if (w_div_ovf) begin
            w_init_lo  = op1_i;
            w_init_neg = 1'b0;
         end
      end else begin
`ifdef MULDIV_FAST_MUL_EN
         {w_init_hi, w_init_lo} = w_fast_prod;
         w_init_neg             = 1'b0;
`else
         w_init_lo = w_mag2;
         w_init_b  = w_mag1;
`endif
      end
   end

   // One iteration: shift-add multiply or restoring divide step
   assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_shift = {r_hi, r_lo[DATA_WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_b};

   always_comb begin
      if (r_funct[2]) begin
         w_step_hi = w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
         w_step_lo = {r_lo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
      end else begin
         w_step_hi = w_sum[DATA_WIDTH:1];
         w_step_lo = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_neg   <= 1'b0;
         r_funct <= '0;
         r_waddr <= '0;
      end else begin
         r_cnt <= (r_state == c_calc) ? r_cnt + 1'b1 : '0;
         if (r_state == c_idle && w_accept) begin
            r_hi    <= w_init_hi;
            r_lo    <= w_init_lo;
            r_b     <= w_init_b;
            r_neg   <= w_init_neg;
            r_funct <= funct3_i;
            r_waddr <= reg_waddr_i;
         end else if (r_state == c_calc) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= c_idle;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:  if (w_accept) w_state_nxt = w_skip ? c_done : c_calc;
         c_calc:  if (flush_i) w_state_nxt = c_idle;
                  else if (r_cnt == c_cnt_last) w_state_nxt = c_done;
         c_done:  w_state_nxt = c_idle;
         default: w_state_nxt = c_idle;
      endcase
   end

   // Final sign correction and result select
   assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
   assign w_quo  = r_neg ? -r_lo : r_lo;
   assign w_rem  = r_neg ? -r_hi : r_hi;

   always_comb begin
      case (r_funct)
         3'd0:       w_result = w_prod[DATA_WIDTH-1:0];
         3'd4, 3'd5: w_result = w_quo;
         3'd6, 3'd7: w_result = w_rem;
         default:    w_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      endcase
   end

   always_comb begin
      busy_o      = (r_state != c_idle);
      reg_we_o    = (r_state == c_done) & ~flush_i;
      reg_waddr_o = reg_we_o ? r_waddr : '0;
      reg_wdata_o = reg_we_o ? w_result : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_exe_muldiv.sv
//=============================================================================
// Module      : tb_exe_muldiv
// Description : Scoreboard bench for exe_muldiv (directed plus random ops).
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_exe_muldiv;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, start, flush;
   logic [2:0]    funct;
   logic [W-1:0]  op1, op2;
   logic [4:0]    waddr;
   logic          busy, we;
   logic [4:0]    waddr_o;
   logic [W-1:0]  wdata_o;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      logic [4:0] wa;
      logic [W-1:0] d;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exe_muldiv #(.DATA_WIDTH(W), .RADDR_WIDTH(5)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .funct3_i    (funct),
      .op1_i       (op1),
      .op2_i       (op2),
      .reg_waddr_i (waddr),
      .flush_i     (flush),
      .busy_o      (busy),
      .reg_we_o    (we),
      .reg_waddr_o (waddr_o),
      .reg_wdata_o (wdata_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      int          ia, ib, q;
      longint      sa, sbv, ubl;
      logic [63:0] p, ua, ub;
      logic        ovf;
      ia  = a;
      ib  = b;
      sa  = ia;
      sbv = ib;
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ubl = longint'(ub);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = ua * ub;   return p[31:0];  end
         3'd1: begin p = sa * sbv;  return p[63:32]; end
         3'd2: begin p = sa * ubl;  return p[63:32]; end
         3'd3: begin p = ua * ub;   return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            q = ia / ib;
            return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            q = ia % ib;
            return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      if (f[2]) begin
         if (b == 0) return 0;
         if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
         return W;
      end
`ifdef MULDIV_FAST_MUL_EN
      return 0;
`else
      return W;
`endif
   endfunction

   // Drive one request for a single accepting edge, then scramble inputs
   task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] wa, input bit push, output int t0);
      exp_t e;
      @(posedge clk); #1;
      funct = f; op1 = a; op2 = b; waddr = wa; start = 1'b1;
      t0 = cyc;
      if (push) begin
         e.cyc = t0 + 1 + lat(f, a, b);
         e.wa  = wa;
         e.d   = model(f, a, b);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      funct = 3'($urandom); op1 = $urandom; op2 = $urandom; waddr = 5'($urandom);
   endtask

   task automatic run(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] wa);
      int t0, l;
      l = lat(f, a, b);
      issue(f, a, b, wa, 1'b1, t0);
      repeat (l + 1) begin
         @(negedge clk);
         chk("busy_active", busy, 1);
      end
      @(negedge clk);
      chk("busy_release", busy, 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 80 && busy; i++) @(negedge clk);
      chk("idle_timeout", busy, 0);
   endtask

   // Write-back monitor: pops the scoreboard on every reg_we_o pulse
   always @(negedge clk) begin
      if (we) begin
         if (sb.size() == 0) begin
            chk("spurious_we", {63'b0, we}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("wb_cycle", cyc, mon_e.cyc);
            chk("wb_waddr", waddr_o, mon_e.wa);
            chk("wb_wdata", wdata_o, mon_e.d);
         end
      end else begin
         chk("idle_waddr", waddr_o, 0);
         chk("idle_wdata", wdata_o, 0);
         if (sb.size() > 0 && sb[0].cyc == cyc) chk("missing_we", {63'b0, we}, 64'd1);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      funct = '0; op1 = '0; op2 = '0; waddr = '0;
      @(negedge clk);
      chk("rst_busy",  busy, 0);
      chk("rst_we",    we, 0);
      chk("rst_waddr", waddr_o, 0);
      chk("rst_wdata", wdata_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed arithmetic vectors
      run(3'd5, 32'd100, 32'd7, 5'd1);
      run(3'd7, 32'd100, 32'd7, 5'd2);
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
      run(3'd5, 32'h1234_5678, 32'd0, 5'd5);
      run(3'd7, 32'd5, 32'd0, 5'd6);
      run(3'd4, -32'sd7, 32'd2, 5'd7);
      run(3'd6, -32'sd7, 32'd2, 5'd8);
      run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
      run(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd11);
      run(3'd0, 32'd3, 32'd5, 5'd12);
      run(3'd4, 32'd7, -32'sd3, 5'd13);
      run(3'd6, -32'sd100, -32'sd7, 5'd14);
      run(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd15);
      run(3'd4, 32'hFFFF_FFF0, 32'd0, 5'd16);
      for (int i = 0; i < 8; i++)
         run(3'($urandom), $urandom, (i == 3) ? 32'd0 : $urandom, 5'($urandom));

      // Flush mid-CALC: no write-back afterwards
      issue(3'd5, 32'd100, 32'd7, 5'd20, 1'b0, t0);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_calc_busy", busy, 1);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_calc_idle", busy, 0);
      repeat (40) begin @(negedge clk); chk("flush_calc_no_we", we, 0); end

      // Flush while in DONE suppresses the pulse
      issue(3'd5, 32'd9, 32'd0, 5'd21, 1'b0, t0);
      chk("done_busy", busy, 1);
      flush = 1'b1;
      #1 chk("flush_done_we", we, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_done_idle", busy, 0);

      // Flush in IDLE blocks a simultaneous start
      @(posedge clk); #1;
      funct = 3'd5; op1 = 32'd50; op2 = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_idle_block", busy, 0);

      // Asynchronous reset mid-CALC
      issue(3'd4, 32'd1000, 32'd13, 5'd22, 1'b0, t0);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("rst_calc_busy", busy, 0);
      chk("rst_calc_we", we, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (40) begin @(negedge clk); chk("rst_calc_no_we", we, 0); end
      run(3'd5, 32'd200, 32'd7, 5'd23);

      // start held high: second request accepted the cycle after DONE
      @(posedge clk); #1;
      funct = 3'd5; op1 = 32'd100; op2 = 32'd7; waddr = 5'd24; start = 1'b1;
      t0 = cyc;
      sb.push_back('{t0 + 1 + W, 5'd24, model(3'd5, 32'd100, 32'd7)});
      sb.push_back('{t0 + 2 + 2 * W + 1, 5'd25, model(3'd7, 32'd200, 32'd7)});
      @(posedge clk); #1;
      funct = 3'd7; op1 = 32'd200; op2 = 32'd7; waddr = 5'd25;
      for (int i = 0; i < 80 && cyc < t0 + W + 2; i++) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("held_gap_idle", busy, 0);
      @(posedge clk); #1;
      chk("held_second_busy", busy, 1);
      start = 1'b0;
      wait_idle();

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
